mssb_tx_arbiter: RTL and testbench

//  Shares the single cmn_uart transmit byte stream (MSSB_TX) between NUM_REQ packet sources.

---
 rtl/mssb_pkg.sv | 21 ++
 rtl/mssb_tx_arbiter_rr_pick.sv | 33 +++
 rtl/mssb_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mssb_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mssb_pkg.sv
// Shared types for the MSSB transmit arbiter.
// State encoding and header byte layout.
package mssb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam logic [3:0] HDR_MARK_DEF = 4'hA;

    function automatic logic [7:0] hdr_byte(
        input logic [3:0] mark,
        input logic [2:0] id
    );
        return {mark, 1'b0, id};
    endfunction

endpackage

// File: rtl/mssb_tx_arbiter_rr_pick.sv
// Round-robin search: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic               hit,
    output logic [2:0]         idx
);

    logic [NUM_REQ-1:0] rot;
    logic [3:0]         sum;

    assign rot = NUM_REQ'({req, req} >> ptr);

    // Walk downward so the lowest rotated position wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                hit = 1'b1;
                sum = {1'b0, ptr} + 4'(k);
                if (sum >= 4'(NUM_REQ))
                    idx = 3'(sum - 4'(NUM_REQ));
                else
                    idx = sum[2:0];
            end
        end
    end

endmodule

// File: rtl/mssb_tx_arbiter.sv
// Packet arbiter sharing one cmn_uart byte stream between sources.
module mssb_tx_arbiter
    import mssb_pkg::*;
#(
    parameter int         NUM_REQ       = 4,
    parameter int         MAX_PKT_BYTES = 256,
    parameter int         TIMEOUT_CYC   = 100000,
    parameter int         GAP_CYC       = 16,
    parameter logic [3:0] HDR_MARK      = HDR_MARK_DEF
) (
    input  logic                 OPB_CLK,
    input  logic                 OPB_RST,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [NUM_REQ*8-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]   REQ_LAST,
    output logic [NUM_REQ-1:0]   REQ_READY,
    output logic [7:0]           UART_DATA,
    output logic                 UART_STB,
    input  logic                 UART_ACK,
    output logic                 BUSY,
    output logic [2:0]           GRANT_ID,
    output logic                 PKT_DONE,
    output logic                 ERR_TIMEOUT,
    output logic                 ERR_OVERLEN,
    input  logic                 ERR_CLR
);

    state_t             state, state_nxt;
    logic [2:0]         rr_ptr;
    logic [15:0]        byte_cnt;
    logic [19:0]        stall_cnt;
    logic [7:0]         gap_cnt;
    logic               last_r;
    logic               pick_hit;
    logic [2:0]         pick_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               vld_g;
    logic               last_g;
    logic [7:0]         data_g;
    logic               abort;
    logic               rdy_g;
    logic               accept;
    logic               ack_byte;
    logic               at_max;
    logic               pkt_end;
    logic               tmo;
    logic               ovl_set;
    logic               gap_done;
    logic [3:0]         ptr_inc;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (REQ_VALID),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    always_comb begin
        gnt_oh = '0;
        vld_g  = 1'b0;
        last_g = 1'b0;
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GRANT_ID == 3'(i)) begin
                gnt_oh[i] = 1'b1;
                vld_g     = REQ_VALID[i];
                last_g    = REQ_LAST[i];
                data_g    = REQ_DATA[8*i +: 8];
            end
        end
    end

    assign abort    = stall_cnt == 20'(TIMEOUT_CYC);
    assign rdy_g    = (state == ST_DATA) & ~UART_STB & ~abort;
    assign accept   = rdy_g & vld_g;
    assign ack_byte = (state == ST_DATA) & UART_STB & UART_ACK;
    assign at_max   = byte_cnt == 16'(MAX_PKT_BYTES);
    assign pkt_end  = ack_byte & (last_r | at_max);
    assign ovl_set  = ack_byte & ~last_r & at_max;
    assign tmo      = (state == ST_DATA) & ~UART_STB & abort;
    assign gap_done = int'(gap_cnt) + 1 >= GAP_CYC;
    assign ptr_inc  = {1'b0, GRANT_ID} + 4'd1;

    assign REQ_READY = rdy_g ? gnt_oh : '0;
    assign BUSY      = state != ST_IDLE;

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (pick_hit) state_nxt = ST_HDR;
            ST_HDR:  if (UART_STB && UART_ACK) state_nxt = ST_DATA;
            ST_DATA: if (tmo || pkt_end) state_nxt = ST_GAP;
            ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            rr_ptr    <= '0;
            GRANT_ID  <= '0;
            UART_DATA <= '0;
            UART_STB  <= 1'b0;
            PKT_DONE  <= 1'b0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            last_r    <= 1'b0;
        end else begin
            PKT_DONE <= 1'b0;
            if (state == ST_IDLE && pick_hit) begin
                GRANT_ID  <= pick_idx;
                byte_cnt  <= '0;
                stall_cnt <= '0;
                last_r    <= 1'b0;
            end
            if (state == ST_HDR) begin
                if (!UART_STB) begin
                    UART_DATA <= hdr_byte(HDR_MARK, GRANT_ID);
                    UART_STB  <= 1'b1;
                end else if (UART_ACK) begin
                    UART_STB <= 1'b0;
                end
            end
            if (accept) begin
                UART_DATA <= data_g;
                last_r    <= last_g;
                UART_STB  <= 1'b1;
                byte_cnt  <= byte_cnt + 16'd1;
                stall_cnt <= '0;
            end else if (ack_byte) begin
                UART_STB <= 1'b0;
            end else if (state == ST_DATA && !UART_STB && !abort) begin
                stall_cnt <= stall_cnt + 20'd1;
            end
            // Packet end: pulse done and move the pointer past the winner.
            if (tmo || pkt_end) begin
                PKT_DONE <= 1'b1;
                gap_cnt  <= '0;
                rr_ptr   <= (ptr_inc == 4'(NUM_REQ)) ? 3'd0 : ptr_inc[2:0];
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            ERR_TIMEOUT <= 1'b0;
            ERR_OVERLEN <= 1'b0;
        end else begin
            if (tmo)
                ERR_TIMEOUT <= 1'b1;
            else if (ERR_CLR)
                ERR_TIMEOUT <= 1'b0;
            if (ovl_set)
                ERR_OVERLEN <= 1'b1;
            else if (ERR_CLR)
                ERR_OVERLEN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mssb_tx_arbiter.sv
// Scoreboard bench for mssb_tx_arbiter with a random-latency UART model.
`timescale 1ns/1ps
module tb_mssb_tx_arbiter;

    localparam int NR = 4;

    logic          OPB_CLK = 1'b0;
    logic          OPB_RST;
    logic [NR-1:0] REQ_VALID;
    logic [NR*8-1:0] REQ_DATA;
    logic [NR-1:0] REQ_LAST;
    logic [NR-1:0] REQ_READY;
    logic [7:0]    UART_DATA;
    logic          UART_STB;
    logic          UART_ACK;
    logic          BUSY;
    logic [2:0]    GRANT_ID;
    logic          PKT_DONE;
    logic          ERR_TIMEOUT;
    logic          ERR_OVERLEN;
    logic          ERR_CLR;

    logic          valid_s [NR];
    logic          last_s  [NR];
    logic [7:0]    data_s  [NR];
    logic          clr_main;
    logic          clr_uart;

    logic [7:0]    exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            ack_cnt = 0;
    int            clr_at = 0;

    always #5 OPB_CLK = ~OPB_CLK;

    always_comb begin
        REQ_VALID = '0;
        REQ_LAST  = '0;
        REQ_DATA  = '0;
        for (int i = 0; i < NR; i++) begin
            REQ_VALID[i]       = valid_s[i];
            REQ_LAST[i]        = last_s[i];
            REQ_DATA[8*i +: 8] = data_s[i];
        end
    end

    assign ERR_CLR = clr_main | clr_uart;

    mssb_tx_arbiter #(
        .NUM_REQ       (NR),
        .MAX_PKT_BYTES (4),
        .TIMEOUT_CYC   (50),
        .GAP_CYC       (4),
        .HDR_MARK      (4'hA)
    ) dut (
        .OPB_CLK     (OPB_CLK),
        .OPB_RST     (OPB_RST),
        .REQ_VALID   (REQ_VALID),
        .REQ_DATA    (REQ_DATA),
        .REQ_LAST    (REQ_LAST),
        .REQ_READY   (REQ_READY),
        .UART_DATA   (UART_DATA),
        .UART_STB    (UART_STB),
        .UART_ACK    (UART_ACK),
        .BUSY        (BUSY),
        .GRANT_ID    (GRANT_ID),
        .PKT_DONE    (PKT_DONE),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_OVERLEN (ERR_OVERLEN),
        .ERR_CLR     (ERR_CLR)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    always @(negedge OPB_CLK)
        if (PKT_DONE) done_cnt++;

    // UART model and output monitor: pops the scoreboard on each ACK.
    initial begin
        int  d;
        bit  abrt;
        logic [7:0] e;
        UART_ACK = 1'b0;
        clr_uart = 1'b0;
        forever begin
            @(negedge OPB_CLK);
            if (OPB_RST || !UART_STB) continue;
            d = $urandom_range(20, 3);
            abrt = 1'b0;
            for (int i = 1; i < d; i++) begin
                @(negedge OPB_CLK);
                if (OPB_RST) begin
                    abrt = 1'b1;
                    break;
                end
            end
            if (abrt) continue;
            if (exp_q.size() == 0) begin
                fail_now("uart_extra_byte");
            end else begin
                e = exp_q.pop_front();
                chk("uart_byte", 32'(UART_DATA), 32'(e));
            end
            UART_ACK = 1'b1;
            ack_cnt++;
            if (clr_at != 0 && ack_cnt == clr_at) clr_uart = 1'b1;
            @(negedge OPB_CLK);
            UART_ACK = 1'b0;
            clr_uart = 1'b0;
        end
    end

    task automatic send(input logic [1:0] src, input int n,
                        input logic [7:0] base, input bit last_fin,
                        output int acc);
        bit stop;
        int w;
        acc = 0;
        stop = 1'b0;
        for (int k = 0; k < n && !stop; k++) begin
            valid_s[src] = 1'b1;
            data_s[src]  = base + 8'(k);
            last_s[src]  = last_fin && (k == n - 1);
            w = 0;
            forever begin
                @(negedge OPB_CLK);
                if (REQ_READY[src]) begin
                    @(posedge OPB_CLK);
                    #1;
                    acc++;
                    break;
                end
                if (OPB_RST ||
                    (PKT_DONE && GRANT_ID == 3'(src) && acc > 0)) begin
                    stop = 1'b1;
                    break;
                end
                if (++w > 400) begin
                    fail_now("send_wait_ready");
                    stop = 1'b1;
                    break;
                end
            end
        end
        valid_s[src] = 1'b0;
        last_s[src]  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int w;
        w = 0;
        @(negedge OPB_CLK);
        while (BUSY || exp_q.size() != 0) begin
            @(negedge OPB_CLK);
            if (++w > 3000) begin
                fail_now(nm);
                break;
            end
        end
    endtask

    initial begin
        int a0, a1, a2;
        int d0;
        int w;
        for (int i = 0; i < NR; i++) begin
            valid_s[i] = 1'b0;
            last_s[i]  = 1'b0;
            data_s[i]  = '0;
        end
        clr_main = 1'b0;
        OPB_RST  = 1'b1;
        repeat (3) @(negedge OPB_CLK);
        chk("rst_outs", {UART_STB, BUSY, PKT_DONE, ERR_TIMEOUT,
            ERR_OVERLEN, GRANT_ID, REQ_READY, UART_DATA}, '0);
        OPB_RST = 1'b0;
        repeat (2) @(negedge OPB_CLK);
        chk("idle_busy", 32'(BUSY), 0);

        // 1: single packet from source 1
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        d0 = done_cnt;
        valid_s[1] = 1'b1;
        data_s[1]  = 8'h11;
        send(2'd1, 1, 8'h11, 1'b0, a1);
        send(2'd1, 1, 8'h22, 1'b0, a0);
        send(2'd1, 1, 8'h33, 1'b1, a2);
        wait_idle("t1_idle");
        chk("t1_done", 32'(done_cnt - d0), 1);
        chk("t1_grant", 32'(GRANT_ID), 1);
        chk("t1_err", {ERR_TIMEOUT, ERR_OVERLEN}, 0);

        // 2a: sources 0 and 2 together, pointer at 2
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        d0 = done_cnt;
        fork
            send(2'd0, 2, 8'h01, 1'b1, a0);
            send(2'd2, 2, 8'h21, 1'b1, a2);
        join
        wait_idle("t2a_idle");
        chk("t2a_done", 32'(done_cnt - d0), 2);
        chk("t2a_grant", 32'(GRANT_ID), 0);

        // 2b: sources 0 and 1 together, pointer at 1
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h14);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        fork
            send(2'd0, 2, 8'h03, 1'b1, a0);
            send(2'd1, 2, 8'h13, 1'b1, a1);
        join
        wait_idle("t2b_idle");
        chk("t2b_grant", 32'(GRANT_ID), 0);

        // 3: overlength from source 3
        exp_q.push_back(8'hA3);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h31 + 8'(k));
        d0 = done_cnt;
        send(2'd3, 6, 8'h31, 1'b0, a2);
        chk("t3_acc", 32'(a2), 4);
        chk("t3_ready", 32'(REQ_READY), 0);
        wait_idle("t3_idle");
        chk("t3_ovl", {ERR_TIMEOUT, ERR_OVERLEN}, 2'b01);
        chk("t3_done", 32'(done_cnt - d0), 1);

        // 4: source 0 stalls after its first byte
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h41);
        d0 = done_cnt;
        send(2'd0, 1, 8'h41, 1'b0, a0);
        chk("t4_pre", 32'(ERR_TIMEOUT), 0);
        w = 0;
        while (!ERR_TIMEOUT && w < 200) begin
            @(negedge OPB_CLK);
            w++;
        end
        if (w < 53 || w > 75)
            chk("t4_tmo_cycles", 32'(w), 32'd53);
        else
            chk("t4_tmo", 32'(ERR_TIMEOUT), 1);
        chk("t4_busy_gap", 32'(BUSY), 1);
        wait_idle("t4_idle");
        chk("t4_done", 32'(done_cnt - d0), 1);

        // 5: clear, then set and clear on the same edge
        clr_main = 1'b1;
        @(negedge OPB_CLK);
        clr_main = 1'b0;
        @(negedge OPB_CLK);
        chk("t5_clr", {ERR_TIMEOUT, ERR_OVERLEN}, 0);
        exp_q.push_back(8'hA3);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h51 + 8'(k));
        clr_at = ack_cnt + 5;
        send(2'd3, 6, 8'h51, 1'b0, a2);
        wait_idle("t5_idle");
        clr_at = 0;
        chk("t5_set_wins", {ERR_TIMEOUT, ERR_OVERLEN}, 2'b01);

        // 6: reset while the header is on the line
        fork
            send(2'd1, 3, 8'h61, 1'b1, a1);
        join_none
        w = 0;
        @(negedge OPB_CLK);
        while (!UART_STB && w < 100) begin
            @(negedge OPB_CLK);
            w++;
        end
        if (w >= 100) fail_now("t6_wait_stb");
        #1 OPB_RST = 1'b1;
        @(negedge OPB_CLK);
        chk("t6_rst_outs", {UART_STB, BUSY, PKT_DONE, ERR_TIMEOUT,
            ERR_OVERLEN, GRANT_ID, REQ_READY, UART_DATA}, '0);
        repeat (3) @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'h71);
        send(2'd2, 1, 8'h71, 1'b1, a2);
        wait_idle("t6_idle");
        chk("t6_grant", 32'(GRANT_ID), 2);
        chk("t6_left", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
